// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - shared state encodings, defaults and width helper for the timer arbiter
package timer_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  localparam int DEF_CNT_W  = 3;
  localparam int DEF_THRESH = 4;

  // Index width for n items, never below one bit so a 2-entry pool still gets a real register.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/timer_share_arbiter_if.sv
// rtl/timer_share_arbiter_if.sv - request/grant bundle between requesters and the shared timer
interface timer_share_arbiter_if import timer_ctrl_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int CNT_W = DEF_CNT_W
);

  logic             tick;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] release_pulse;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] expired;
  logic             busy;
  logic [CNT_W-1:0] count;

  modport master (
    output tick, req, release_pulse,
    input  grant, expired, busy, count
  );

  modport slave (
    input  tick, req, release_pulse,
    output grant, expired, busy, count
  );

endinterface

// File: rtl/sat_timeout_counter.sv
// rtl/sat_timeout_counter.sv - up counter that sticks at all-ones instead of wrapping
module sat_timeout_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/timer_share_arbiter.sv
// rtl/timer_share_arbiter.sv - round-robin owner of one saturating timeout counter
module timer_share_arbiter import timer_ctrl_pkg::*; #(
  parameter int N_REQ  = 2,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int THRESH = DEF_THRESH
) (
  input logic                  clock,
  input logic                  clear,
  timer_share_arbiter_if.slave bus
);

  localparam int               OW  = idx_width(N_REQ);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [OW-1:0]    owner;
  logic [OW-1:0]    last_owner;
  logic [OW-1:0]    sel_idx;
  logic [OW-1:0]    cand;
  logic             sel_found;
  logic             owner_active;
  logic             owner_exit;
  logic             cnt_clear;
  logic             cnt_en;
  logic [CNT_W-1:0] count;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] expired_q;

  // Search starts one past the previous owner, so a releasing owner yields to any other waiter.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = OW'((int'(last_owner) + 1 + k) % N_REQ);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign owner_active = (state == ST_RUN) || (state == ST_EXPIRED);
  assign owner_exit   = owner_active && (bus.release_pulse[owner] || !bus.req[owner]);
  assign cnt_clear    = clear || (state == ST_LOAD);
  // Count freezes on the exit edge so software can read where the owner stopped.
  assign cnt_en       = bus.tick && owner_active && !owner_exit;

  sat_timeout_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clock (clock),
    .clear (cnt_clear),
    .enable(cnt_en),
    .count (count)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= ST_IDLE;
      owner      <= '0;
      last_owner <= OW'(N_REQ - 1);
      grant_q    <= '0;
      expired_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            state   <= ST_LOAD;
            owner   <= sel_idx;
            grant_q <= ONE << sel_idx;
          end
        end
        ST_LOAD: begin
          state <= ST_RUN;
        end
        ST_RUN, ST_EXPIRED: begin
          if (owner_exit) begin
            state      <= ST_IDLE;
            last_owner <= owner;
            grant_q    <= '0;
            expired_q  <= '0;
          end else if ((state == ST_RUN) && (count >= CNT_W'(THRESH))) begin
            state     <= ST_EXPIRED;
            expired_q <= ONE << owner;
          end
        end
        default: begin
          state     <= ST_IDLE;
          grant_q   <= '0;
          expired_q <= '0;
        end
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.expired = expired_q;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.count   = count;

endmodule

// File: tb/tb_timer_share_arbiter.sv
// tb/tb_timer_share_arbiter.sv - directed self-checking bench for timer_share_arbiter
module tb_timer_share_arbiter;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   checks = 0;
  int   failures = 0;

  timer_share_arbiter_if #(.N_REQ(2), .CNT_W(3)) bus ();

  timer_share_arbiter #(
    .N_REQ (2),
    .CNT_W (3),
    .THRESH(4)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear(input int n);
    clear = 1'b1;
    bus.req = '0;
    bus.tick = 1'b0;
    bus.release_pulse = '0;
    repeat (n) cyc();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    do_clear(2);
    checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", bus.grant); end
    checks++; if (bus.expired !== 2'b00) begin failures++; $display("FAIL reset_expired got=%b exp=00", bus.expired); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
  endtask

  task automatic test_basic();
    logic [2:0] exp_cnt [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
    logic [1:0] exp_exp;
    bus.req = 2'b01;
    bus.tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      exp_exp = (i >= 6) ? 2'b01 : 2'b00;
      checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL basic_grant[%0d] got=%b exp=01", i, bus.grant); end
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy[%0d] got=%b exp=1", i, bus.busy); end
      checks++; if (bus.count !== exp_cnt[i]) begin failures++; $display("FAIL basic_count[%0d] got=%0d exp=%0d", i, bus.count, exp_cnt[i]); end
      checks++; if (bus.expired !== exp_exp) begin failures++; $display("FAIL basic_expired[%0d] got=%b exp=%b", i, bus.expired, exp_exp); end
    end
    bus.release_pulse = 2'b01;
    bus.req = 2'b00;
    cyc();
    bus.release_pulse = 2'b00;
    checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL basic_rel_grant got=%b exp=00", bus.grant); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_rel_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.count !== 3'd7) begin failures++; $display("FAIL basic_rel_count got=%0d exp=7", bus.count); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [3] = '{2'b01, 2'b10, 2'b01};
    do_clear(1);
    bus.req = 2'b11;
    bus.tick = 1'b1;
    for (int r = 0; r < 3; r++) begin
      cyc();
      checks++; if (bus.grant !== exp_g[r]) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", r, bus.grant, exp_g[r]); end
      repeat (6) cyc();
      checks++; if (bus.expired !== exp_g[r]) begin failures++; $display("FAIL rr_expired[%0d] got=%b exp=%b", r, bus.expired, exp_g[r]); end
      bus.release_pulse = exp_g[r];
      cyc();
      bus.release_pulse = 2'b00;
      checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL rr_idle_grant[%0d] got=%b exp=00", r, bus.grant); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rr_idle_busy[%0d] got=%b exp=0", r, bus.busy); end
    end
    bus.req = 2'b00;
    cyc();
  endtask

  task automatic test_tick_toggle();
    logic [2:0] exp_c [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4};
    logic [1:0] exp_e;
    do_clear(1);
    bus.req = 2'b01;
    bus.tick = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 8; i++) begin
      bus.tick = (i % 2 == 0);
      cyc();
      exp_e = (i == 7) ? 2'b01 : 2'b00;
      checks++; if (bus.count !== exp_c[i]) begin failures++; $display("FAIL tog_count[%0d] got=%0d exp=%0d", i, bus.count, exp_c[i]); end
      checks++; if (bus.expired !== exp_e) begin failures++; $display("FAIL tog_expired[%0d] got=%b exp=%b", i, bus.expired, exp_e); end
    end
    bus.release_pulse = 2'b01;
    bus.req = 2'b00;
    cyc();
    bus.release_pulse = 2'b00;
  endtask

  task automatic test_drop_req();
    do_clear(1);
    bus.req = 2'b01;
    bus.tick = 1'b1;
    repeat (4) cyc();
    checks++; if (bus.count !== 3'd2) begin failures++; $display("FAIL drop_pre_count got=%0d exp=2", bus.count); end
    bus.req = 2'b00;
    cyc();
    checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL drop_grant got=%b exp=00", bus.grant); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL drop_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.count !== 3'd2) begin failures++; $display("FAIL drop_count got=%0d exp=2", bus.count); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (bus.expired !== 2'b00) begin failures++; $display("FAIL drop_expired[%0d] got=%b exp=00", i, bus.expired); end
    end
    bus.req = 2'b01;
    cyc();
    checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL drop_regrant got=%b exp=01", bus.grant); end
    cyc();
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL drop_reload got=%0d exp=0", bus.count); end
    bus.release_pulse = 2'b01;
    bus.req = 2'b00;
    cyc();
    bus.release_pulse = 2'b00;
  endtask

  task automatic test_nonowner_release();
    logic [1:0] exp_e;
    do_clear(1);
    bus.req = 2'b01;
    bus.tick = 1'b1;
    cyc();
    for (int i = 1; i <= 6; i++) begin
      bus.release_pulse = (i == 3) ? 2'b10 : 2'b00;
      cyc();
      exp_e = (i == 6) ? 2'b01 : 2'b00;
      checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL nonown_grant[%0d] got=%b exp=01", i, bus.grant); end
      checks++; if (bus.expired !== exp_e) begin failures++; $display("FAIL nonown_expired[%0d] got=%b exp=%b", i, bus.expired, exp_e); end
    end
    bus.release_pulse = 2'b01;
    bus.req = 2'b00;
    cyc();
    bus.release_pulse = 2'b00;
  endtask

  task automatic test_clear_expired();
    do_clear(1);
    bus.req = 2'b01;
    bus.tick = 1'b1;
    repeat (7) cyc();
    bus.req = 2'b11;
    bus.release_pulse = 2'b01;
    cyc();
    bus.release_pulse = 2'b00;
    checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL clr_idle_gap got=%b exp=00", bus.grant); end
    cyc();
    checks++; if (bus.grant !== 2'b10) begin failures++; $display("FAIL clr_rr_grant got=%b exp=10", bus.grant); end
    repeat (8) cyc();
    checks++; if (bus.count !== 3'd7) begin failures++; $display("FAIL clr_sat_count got=%0d exp=7", bus.count); end
    checks++; if (bus.expired !== 2'b10) begin failures++; $display("FAIL clr_pre_expired got=%b exp=10", bus.expired); end
    clear = 1'b1;
    cyc();
    checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL clr_grant got=%b exp=00", bus.grant); end
    checks++; if (bus.expired !== 2'b00) begin failures++; $display("FAIL clr_expired got=%b exp=00", bus.expired); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", bus.count); end
    clear = 1'b0;
    cyc();
    checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL clr_priority got=%b exp=01", bus.grant); end
    bus.req = 2'b00;
    cyc();
  endtask

  initial begin
    bus.req = '0;
    bus.tick = 1'b0;
    bus.release_pulse = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_tick_toggle();
    test_drop_req();
    test_nonowner_release();
    test_clear_expired();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
